// File: rtl/superh16_pkg.sv
// Shared types for the superh16 branch resolution slice.
// Opcode encodings, redirect FSM states and ROB age helper.
package superh16_pkg;

  localparam int ROB_W = 9;

  typedef enum logic [3:0] {
    OP_BEQ  = 4'd0,
    OP_BNE  = 4'd1,
    OP_BLT  = 4'd2,
    OP_BGE  = 4'd3,
    OP_BLTU = 4'd4,
    OP_BGEU = 4'd5,
    OP_JAL  = 4'd6,
    OP_JALR = 4'd7
  } uop_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_SHADOW = 2'd2
  } br_fsm_t;

  // Distance from the ROB head; smaller means older, wrap is implicit.
  function automatic logic [ROB_W-1:0] rob_age(
    input logic [ROB_W-1:0] idx,
    input logic [ROB_W-1:0] head
  );
    return idx - head;
  endfunction

endpackage

// File: rtl/superh16_branch_alu.sv
// Per-port branch evaluation: condition, next PC, link value
// and mispredict flag, purely combinational.
module superh16_branch_alu
  import superh16_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int VADDR_WIDTH = 64,
  parameter int IMM_W       = 21
) (
  input  uop_opcode_t            opcode,
  input  logic [XLEN-1:0]        src1,
  input  logic [XLEN-1:0]        src2,
  input  logic [VADDR_WIDTH-1:0] pc,
  input  logic [IMM_W-1:0]       imm,
  input  logic                   pred_taken,
  input  logic [VADDR_WIDTH-1:0] pred_target,
  output logic                   taken,
  output logic [VADDR_WIDTH-1:0] next_pc,
  output logic [XLEN-1:0]        link_data,
  output logic                   mispred
);

  logic [VADDR_WIDTH-1:0] imm_sext;
  logic [VADDR_WIDTH-1:0] pc_plus4;
  logic [VADDR_WIDTH-1:0] br_tgt;
  logic [VADDR_WIDTH-1:0] jalr_tgt;
  logic                   is_link;
  logic                   is_jalr;

  assign imm_sext = {{(VADDR_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign pc_plus4 = pc + VADDR_WIDTH'(4);
  assign br_tgt   = pc + imm_sext;
  assign jalr_tgt = (src1[VADDR_WIDTH-1:0] + imm_sext)
                  & ~VADDR_WIDTH'(1);

  always_comb begin
    taken   = 1'b0;
    is_link = 1'b0;
    is_jalr = 1'b0;
    case (opcode)
      OP_BEQ:  taken = (src1 == src2);
      OP_BNE:  taken = (src1 != src2);
      OP_BLT:  taken = ($signed(src1) < $signed(src2));
      OP_BGE:  taken = ($signed(src1) >= $signed(src2));
      OP_BLTU: taken = (src1 < src2);
      OP_BGEU: taken = (src1 >= src2);
      OP_JAL: begin
        taken   = 1'b1;
        is_link = 1'b1;
      end
      OP_JALR: begin
        taken   = 1'b1;
        is_link = 1'b1;
        is_jalr = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (taken) next_pc = is_jalr ? jalr_tgt : br_tgt;
    link_data = is_link ? XLEN'(pc_plus4) : '0;
    mispred = (taken != pred_taken)
            || (taken && (next_pc != pred_target));
  end

endmodule

// File: rtl/superh16_branch_unit_mp.sv
// Multi-port branch resolution: oldest-mispredict select, squash
// of younger work and a single held frontend redirect.
module superh16_branch_unit_mp
  import superh16_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int XLEN          = 64,
  parameter int VADDR_WIDTH   = 64,
  parameter int IMM_W         = 21,
  parameter int ROB_IDX_BITS  = 9,
  parameter int PHYS_REG_BITS = 9
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_PORTS-1:0]                       in_valid,
  input  uop_opcode_t [NUM_PORTS-1:0]                in_opcode,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]             in_src1,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]             in_src2,
  input  logic [NUM_PORTS-1:0][VADDR_WIDTH-1:0]      in_pc,
  input  logic [NUM_PORTS-1:0][IMM_W-1:0]            in_imm,
  input  logic [NUM_PORTS-1:0]                       in_pred_taken,
  input  logic [NUM_PORTS-1:0][VADDR_WIDTH-1:0]      in_pred_target,
  input  logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0]    in_dst_tag,
  input  logic [NUM_PORTS-1:0][ROB_IDX_BITS-1:0]     in_rob_idx,
  input  logic [ROB_IDX_BITS-1:0]                    rob_head,
  input  logic                                       flush_i,
  output logic [NUM_PORTS-1:0]                       res_valid,
  output logic [NUM_PORTS-1:0][XLEN-1:0]             res_data,
  output logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0]    res_dst_tag,
  output logic [NUM_PORTS-1:0][ROB_IDX_BITS-1:0]     res_rob_idx,
  output logic [NUM_PORTS-1:0]                       res_taken,
  output logic [NUM_PORTS-1:0]                       res_mispred,
  output logic [NUM_PORTS-1:0][VADDR_WIDTH-1:0]      res_target,
  output logic                                       redir_valid,
  input  logic                                       redir_ready,
  output logic [VADDR_WIDTH-1:0]                     redir_pc,
  output logic [ROB_IDX_BITS-1:0]                    redir_rob_idx
);

  logic [NUM_PORTS-1:0]                    alu_taken;
  logic [NUM_PORTS-1:0]                    alu_mis;
  logic [NUM_PORTS-1:0][VADDR_WIDTH-1:0]   alu_tgt;
  logic [NUM_PORTS-1:0][XLEN-1:0]          alu_link;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_alu
    superh16_branch_alu #(
      .XLEN        (XLEN),
      .VADDR_WIDTH (VADDR_WIDTH),
      .IMM_W       (IMM_W)
    ) u_alu (
      .opcode      (in_opcode[p]),
      .src1        (in_src1[p]),
      .src2        (in_src2[p]),
      .pc          (in_pc[p]),
      .imm         (in_imm[p]),
      .pred_taken  (in_pred_taken[p]),
      .pred_target (in_pred_target[p]),
      .taken       (alu_taken[p]),
      .next_pc     (alu_tgt[p]),
      .link_data   (alu_link[p]),
      .mispred     (alu_mis[p])
    );
  end

  br_fsm_t                  state_q, state_d;
  logic [ROB_IDX_BITS-1:0]  bnd_q, bnd_d;
  logic [VADDR_WIDTH-1:0]   redir_pc_q, redir_pc_d;
  logic                     redir_valid_q, redir_valid_d;

  logic [NUM_PORTS-1:0]                    res_valid_q, res_valid_d;
  logic [NUM_PORTS-1:0]                    res_taken_q, res_taken_d;
  logic [NUM_PORTS-1:0]                    res_mis_q, res_mis_d;
  logic [NUM_PORTS-1:0][XLEN-1:0]          res_data_q, res_data_d;
  logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0] res_tag_q, res_tag_d;
  logic [NUM_PORTS-1:0][ROB_IDX_BITS-1:0]  res_rob_q, res_rob_d;
  logic [NUM_PORTS-1:0][VADDR_WIDTH-1:0]   res_tgt_q, res_tgt_d;

  logic [ROB_IDX_BITS-1:0]                 bnd_age;
  logic [NUM_PORTS-1:0][ROB_IDX_BITS-1:0]  age;
  logic [NUM_PORTS-1:0]                    alive;
  logic [NUM_PORTS-1:0]                    keep;
  logic                                    win_found;
  logic [ROB_IDX_BITS-1:0]                 win_age;
  logic [ROB_IDX_BITS-1:0]                 win_rob;
  logic [VADDR_WIDTH-1:0]                  win_pc;
  logic                                    accept;

  // Boundary squash first, then oldest surviving mispredict wins.
  always_comb begin
    bnd_age   = rob_age(bnd_q, rob_head);
    age       = '0;
    alive     = '0;
    keep      = '0;
    win_found = 1'b0;
    win_age   = '0;
    win_rob   = '0;
    win_pc    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      age[p]   = rob_age(in_rob_idx[p], rob_head);
      alive[p] = in_valid[p] && !flush_i
              && ((state_q == ST_IDLE) || !(age[p] > bnd_age));
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (alive[p] && alu_mis[p]
          && (!win_found || (age[p] < win_age))) begin
        win_found = 1'b1;
        win_age   = age[p];
        win_rob   = in_rob_idx[p];
        win_pc    = alu_tgt[p];
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      keep[p] = alive[p] && (!win_found || !(age[p] > win_age));
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      res_valid_d[p] = keep[p];
      res_taken_d[p] = keep[p] & alu_taken[p];
      res_mis_d[p]   = keep[p] & alu_mis[p];
      res_data_d[p]  = keep[p] ? alu_link[p] : '0;
      res_tag_d[p]   = keep[p] ? in_dst_tag[p] : '0;
      res_rob_d[p]   = keep[p] ? in_rob_idx[p] : '0;
      res_tgt_d[p]   = keep[p] ? alu_tgt[p] : '0;
    end
  end

  assign accept = redir_valid_q && redir_ready;

  always_comb begin
    state_d       = state_q;
    bnd_d         = bnd_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = redir_valid_q;
    if (flush_i) begin
      state_d       = ST_IDLE;
      redir_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHADOW: begin
          if (win_found) begin
            state_d       = ST_PEND;
            bnd_d         = win_rob;
            redir_pc_d    = win_pc;
            redir_valid_d = 1'b1;
          end
        end
        ST_PEND: begin
          // A newer-older mispredict survives an accept in the same cycle.
          if (win_found) begin
            bnd_d         = win_rob;
            redir_pc_d    = win_pc;
            redir_valid_d = 1'b1;
          end else if (accept) begin
            state_d       = ST_SHADOW;
            redir_valid_d = 1'b0;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          redir_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bnd_q         <= '0;
      redir_pc_q    <= '0;
      redir_valid_q <= 1'b0;
      res_valid_q   <= '0;
      res_taken_q   <= '0;
      res_mis_q     <= '0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      res_rob_q     <= '0;
      res_tgt_q     <= '0;
    end else begin
      state_q       <= state_d;
      bnd_q         <= bnd_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      res_mis_q     <= res_mis_d;
      res_data_q    <= res_data_d;
      res_tag_q     <= res_tag_d;
      res_rob_q     <= res_rob_d;
      res_tgt_q     <= res_tgt_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_taken     = res_taken_q;
  assign res_mispred   = res_mis_q;
  assign res_data      = res_data_q;
  assign res_dst_tag   = res_tag_q;
  assign res_rob_idx   = res_rob_q;
  assign res_target    = res_tgt_q;
  assign redir_valid   = redir_valid_q;
  assign redir_pc      = redir_pc_q;
  assign redir_rob_idx = bnd_q;

endmodule

// File: tb/tb_superh16_branch_unit_mp.sv
// Directed scoreboard bench for superh16_branch_unit_mp.
// Expected results are queued at drive time, checked after the edge.
module tb_superh16_branch_unit_mp;
  import superh16_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            in_valid;
  uop_opcode_t [1:0]     in_opcode;
  logic [1:0][63:0]      in_src1, in_src2, in_pc, in_pred_target;
  logic [1:0][20:0]      in_imm;
  logic [1:0]            in_pred_taken;
  logic [1:0][8:0]       in_dst_tag, in_rob_idx;
  logic [8:0]            rob_head;
  logic                  flush_i;
  logic [1:0]            res_valid, res_taken, res_mispred;
  logic [1:0][63:0]      res_data, res_target;
  logic [1:0][8:0]       res_dst_tag, res_rob_idx;
  logic                  redir_valid, redir_ready;
  logic [63:0]           redir_pc;
  logic [8:0]            redir_rob_idx;

  superh16_branch_unit_mp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_opcode      (in_opcode),
    .in_src1        (in_src1),
    .in_src2        (in_src2),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .in_dst_tag     (in_dst_tag),
    .in_rob_idx     (in_rob_idx),
    .rob_head       (rob_head),
    .flush_i        (flush_i),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_dst_tag    (res_dst_tag),
    .res_rob_idx    (res_rob_idx),
    .res_taken      (res_taken),
    .res_mispred    (res_mispred),
    .res_target     (res_target),
    .redir_valid    (redir_valid),
    .redir_ready    (redir_ready),
    .redir_pc       (redir_pc),
    .redir_rob_idx  (redir_rob_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       v;
    logic [1:0]       tk;
    logic [1:0]       mp;
    logic [1:0][63:0] tgt;
    logic [1:0][63:0] dat;
    logic [1:0][8:0]  tag;
    logic [1:0][8:0]  rob;
    logic             rv;
    logic [63:0]      rpc;
    logic [8:0]       rrob;
  } exp_t;

  exp_t e;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_valid       = '0;
    in_opcode[0]   = OP_BEQ;
    in_opcode[1]   = OP_BEQ;
    in_src1        = '0;
    in_src2        = '0;
    in_pc          = '0;
    in_imm         = '0;
    in_pred_taken  = '0;
    in_pred_target = '0;
    in_dst_tag     = '0;
    in_rob_idx     = '0;
    flush_i        = 1'b0;
    e.v = '0; e.tk = '0; e.mp = '0;
    e.tgt = '0; e.dat = '0; e.tag = '0; e.rob = '0;
    e.rv = 1'b0; e.rpc = '0; e.rrob = '0;
  endtask

  task automatic port(input int p, input uop_opcode_t op,
                      input logic [63:0] s1, input logic [63:0] s2,
                      input logic [63:0] pc, input logic [20:0] imm,
                      input logic pt, input logic [63:0] ptgt,
                      input logic [8:0] tag, input logic [8:0] rob);
    in_valid[p]       = 1'b1;
    in_opcode[p]      = op;
    in_src1[p]        = s1;
    in_src2[p]        = s2;
    in_pc[p]          = pc;
    in_imm[p]         = imm;
    in_pred_taken[p]  = pt;
    in_pred_target[p] = ptgt;
    in_dst_tag[p]     = tag;
    in_rob_idx[p]     = rob;
  endtask

  task automatic ex_port(input int p, input logic tk, input logic mp,
                         input logic [63:0] tgt, input logic [63:0] dat,
                         input logic [8:0] tag, input logic [8:0] rob);
    e.v[p] = 1'b1; e.tk[p] = tk; e.mp[p] = mp;
    e.tgt[p] = tgt; e.dat[p] = dat; e.tag[p] = tag; e.rob[p] = rob;
  endtask

  task automatic ex_redir(input logic [63:0] pc, input logic [8:0] rob);
    e.rv = 1'b1; e.rpc = pc; e.rrob = rob;
  endtask

  task automatic cycle(input string name);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s.v%0d", name, p), 64'(res_valid[p]), 64'(x.v[p]));
      chk($sformatf("%s.tk%0d", name, p), 64'(res_taken[p]), 64'(x.tk[p]));
      chk($sformatf("%s.mp%0d", name, p), 64'(res_mispred[p]), 64'(x.mp[p]));
      chk($sformatf("%s.tgt%0d", name, p), res_target[p], x.tgt[p]);
      chk($sformatf("%s.dat%0d", name, p), res_data[p], x.dat[p]);
      chk($sformatf("%s.tag%0d", name, p), 64'(res_dst_tag[p]), 64'(x.tag[p]));
      chk($sformatf("%s.rob%0d", name, p), 64'(res_rob_idx[p]), 64'(x.rob[p]));
    end
    chk($sformatf("%s.rv", name), 64'(redir_valid), 64'(x.rv));
    if (x.rv) begin
      chk($sformatf("%s.rpc", name), redir_pc, x.rpc);
      chk($sformatf("%s.rrob", name), 64'(redir_rob_idx), 64'(x.rrob));
    end
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    redir_ready = 1'b0;
    rob_head = '0;
    clr();
    cycle("reset");
    rst_n = 1'b1;

    port(0, uop_opcode_t'(4'hF), 64'd1, 64'd1, 64'h50, 21'h8,
         1'b0, 64'h0, 9'd4, 9'd0);
    ex_port(0, 1'b0, 1'b0, 64'h54, 64'h0, 9'd4, 9'd0);
    cycle("unk_op");

    port(0, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd3, 9'd1);
    ex_port(0, 1'b1, 1'b0, 64'h1040, 64'h0, 9'd3, 9'd1);
    cycle("beq_ok");
    cycle("beq_noredir");

    port(0, OP_BLT, '1, 64'd0, 64'h2000, 21'h20,
         1'b0, 64'h0, 9'd5, 9'd2);
    ex_port(0, 1'b1, 1'b1, 64'h2020, 64'h0, 9'd5, 9'd2);
    ex_redir(64'h2020, 9'd2);
    cycle("blt_mis");
    redir_ready = 1'b1;
    cycle("blt_accept");
    redir_ready = 1'b0;

    port(0, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd1, 9'd4);
    port(1, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd2, 9'd1);
    ex_port(1, 1'b1, 1'b0, 64'h1040, 64'h0, 9'd2, 9'd1);
    cycle("shadow_sq");

    flush_i = 1'b1;
    port(0, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd1, 9'd1);
    cycle("shadow_flush");

    port(0, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd6, 9'd9);
    ex_port(0, 1'b1, 1'b0, 64'h1040, 64'h0, 9'd6, 9'd9);
    cycle("idle_after_flush");

    port(0, OP_JALR, 64'h3005, 64'd0, 64'h5000, 21'd2,
         1'b1, 64'h3004, 9'd7, 9'd5);
    ex_port(0, 1'b1, 1'b1, 64'h3006, 64'h5004, 9'd7, 9'd5);
    ex_redir(64'h3006, 9'd5);
    cycle("jalr_mis");
    redir_ready = 1'b1;
    cycle("jalr_accept");
    redir_ready = 1'b0;
    flush_i = 1'b1;
    cycle("jalr_flush");

    rob_head = 9'd5;
    port(0, OP_BNE, 64'd1, 64'd2, 64'h100, 21'h10,
         1'b0, 64'h0, 9'd8, 9'd10);
    port(1, OP_BGEU, 64'd3, 64'd2, 64'h200, 21'h8,
         1'b0, 64'h0, 9'd9, 9'd7);
    ex_port(1, 1'b1, 1'b1, 64'h208, 64'h0, 9'd9, 9'd7);
    ex_redir(64'h208, 9'd7);
    cycle("oldest_sel");
    redir_ready = 1'b1;
    cycle("oldest_accept");
    redir_ready = 1'b0;
    flush_i = 1'b1;
    cycle("oldest_flush");

    rob_head = 9'd510;
    port(0, OP_BLTU, 64'd1, 64'd2, 64'h400, 21'h40,
         1'b0, 64'h0, 9'd10, 9'd1);
    ex_port(0, 1'b1, 1'b1, 64'h440, 64'h0, 9'd10, 9'd1);
    ex_redir(64'h440, 9'd1);
    cycle("wrap_mis");
    ex_redir(64'h440, 9'd1);
    cycle("wrap_hold1");
    port(0, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd11, 9'd4);
    ex_redir(64'h440, 9'd1);
    cycle("wrap_hold2");
    ex_redir(64'h440, 9'd1);
    cycle("wrap_hold3");

    port(0, OP_JAL, 64'd0, 64'd0, 64'h600, 21'h100,
         1'b0, 64'h0, 9'd12, 9'd511);
    port(1, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd13, 9'd3);
    ex_port(0, 1'b1, 1'b1, 64'h700, 64'h604, 9'd12, 9'd511);
    ex_redir(64'h700, 9'd511);
    cycle("wrap_replace");

    redir_ready = 1'b1;
    port(0, OP_BGE, 64'd0, 64'd0, 64'h800, 21'h4,
         1'b0, 64'h0, 9'd14, 9'd510);
    ex_port(0, 1'b1, 1'b1, 64'h804, 64'h0, 9'd14, 9'd510);
    ex_redir(64'h804, 9'd510);
    cycle("accept_and_older");
    cycle("accept2");
    redir_ready = 1'b0;
    flush_i = 1'b1;
    cycle("flush2");

    port(0, OP_BNE, 64'd1, 64'd1, 64'h900, 21'h40,
         1'b1, 64'h940, 9'd15, 9'd20);
    ex_port(0, 1'b0, 1'b1, 64'h904, 64'h0, 9'd15, 9'd20);
    ex_redir(64'h904, 9'd20);
    cycle("pend_again");

    rst_n = 1'b0;
    port(0, OP_BEQ, 64'd5, 64'd5, 64'h1000, 21'h40,
         1'b1, 64'h1040, 9'd16, 9'd21);
    cycle("mid_reset");
    rst_n = 1'b1;
    cycle("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
